uart_sel_rx: RTL and testbench



---
 rtl/uart_sel_rx_pkg.sv | 24 ++
 rtl/uart_byte_rx.sv | 114 +++++++++++
 rtl/uart_sel_rx.sv | 117 +++++++++++
 tb/tb_uart_sel_rx.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_sel_rx_pkg.sv
// Shared types and constants for the UART selector receiver.
// Holds the frame header, FSM encodings and bit-time derivation.
package uart_sel_rx_pkg;

  localparam logic [7:0] HDR = 8'hA5;

  typedef enum logic [1:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP
  } byte_st_e;

  typedef enum logic [1:0] {
    F_HDR,
    F_CMD,
    F_SUM
  } frame_st_e;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: 2-flop synchronizer, mid-bit sampling FSM.
// Pulses byte_valid_o or byte_err_o one clock after the stop sample.
module uart_byte_rx
  import uart_sel_rx_pkg::*;
#(
  parameter int CPB = 434
) (
  input  logic       s_clk,
  input  logic       s_rst_n,
  input  logic       rx_in,
  output logic       byte_valid_o,
  output logic       byte_err_o,
  output logic [7:0] byte_data_o
);

  localparam int CW = $clog2(CPB);
  localparam logic [CW-1:0] FULL = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);

  logic [1:0]    sync_q;
  logic          prev_q;
  byte_st_e      bst_q, bst_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic          hold_q, hold_d;
  logic          done_q, done_d;
  logic          stop_q, stop_d;
  logic          valid_q, err_q;
  logic          rx_s;

  assign rx_s = sync_q[1];

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      bst_q   <= B_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      stop_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx_in};
      prev_q  <= rx_s;
      bst_q   <= bst_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      stop_q  <= stop_d;
      valid_q <= done_q & stop_q;
      err_q   <= done_q & ~stop_q;
    end
  end

  always_comb begin
    bst_d  = bst_q;
    cnt_d  = cnt_q + 1'b1;
    idx_d  = idx_q;
    sh_d   = sh_q;
    hold_d = hold_q;
    done_d = 1'b0;
    stop_d = stop_q;
    unique case (bst_q)
      B_IDLE: begin
        cnt_d = '0;
        if (prev_q && !rx_s) bst_d = B_START;
      end
      B_START: begin
        if (cnt_q == HALF) begin
          cnt_d = '0;
          idx_d = '0;
          bst_d = rx_s ? B_IDLE : B_DATA;
        end
      end
      B_DATA: begin
        if (cnt_q == FULL) begin
          cnt_d = '0;
          sh_d  = {rx_s, sh_q[7:1]};
          idx_d = idx_q + 1'b1;
          if (idx_q == 3'd7) bst_d = B_STOP;
        end
      end
      B_STOP: begin
        // a broken stop bit parks here until the line idles high
        if (hold_q) begin
          cnt_d = '0;
          if (rx_s) begin
            hold_d = 1'b0;
            bst_d  = B_IDLE;
          end
        end else if (cnt_q == FULL) begin
          cnt_d  = '0;
          done_d = 1'b1;
          stop_d = rx_s;
          if (rx_s) bst_d = B_IDLE;
          else hold_d = 1'b1;
        end
      end
      default: bst_d = B_IDLE;
    endcase
  end

  assign byte_valid_o = valid_q;
  assign byte_err_o   = err_q;
  assign byte_data_o  = sh_q;

endmodule

// File: rtl/uart_sel_rx.sv
// UART command receiver: validates HDR/CMD/SUM frames and
// drives the music selector with a one-cycle update strobe.
module uart_sel_rx
  import uart_sel_rx_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_CLKS = 50_000
) (
  input  logic       s_clk,
  input  logic       s_rst_n,
  input  logic       rx_in,
  output logic [3:0] data_sel,
  output logic       data_sel_en,
  output logic       frame_err
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam int TW  = $clog2(TIMEOUT_CLKS);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

  if (CPB < 8) begin : g_cpb_chk
    $error("CLKS_PER_BIT must be at least 8");
  end

  logic       bv, be;
  logic [7:0] bd;

  uart_byte_rx #(.CPB(CPB)) u_byte (
    .s_clk       (s_clk),
    .s_rst_n     (s_rst_n),
    .rx_in       (rx_in),
    .byte_valid_o(bv),
    .byte_err_o  (be),
    .byte_data_o (bd)
  );

  frame_st_e     fst_q, fst_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [3:0]    sel_q, sel_d;
  logic          en_q, en_d;
  logic          err_q, err_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_hit;

  assign tmo_hit = (tmo_q == TMO_LAST);

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      fst_q <= F_HDR;
      cmd_q <= '0;
      sel_q <= '0;
      en_q  <= 1'b0;
      err_q <= 1'b0;
      tmo_q <= '0;
    end else begin
      fst_q <= fst_d;
      cmd_q <= cmd_d;
      sel_q <= sel_d;
      en_q  <= en_d;
      err_q <= err_d;
      tmo_q <= tmo_d;
    end
  end

  always_comb begin
    fst_d = fst_q;
    cmd_d = cmd_q;
    sel_d = sel_q;
    en_d  = 1'b0;
    err_d = 1'b0;
    tmo_d = tmo_q + 1'b1;
    if (fst_q == F_HDR || bv) tmo_d = '0;
    unique case (fst_q)
      F_HDR: begin
        if (bv && bd == HDR) fst_d = F_CMD;
      end
      F_CMD: begin
        // a repeated header resyncs the frame
        if (bv) begin
          if (bd == HDR) begin
            fst_d = F_CMD;
          end else if (bd[7:4] == 4'h0) begin
            cmd_d = bd;
            fst_d = F_SUM;
          end else begin
            err_d = 1'b1;
            fst_d = F_HDR;
          end
        end else if (be || tmo_hit) begin
          err_d = 1'b1;
          fst_d = F_HDR;
        end
      end
      F_SUM: begin
        if (bv) begin
          fst_d = F_HDR;
          if (bd == (HDR ^ cmd_q)) begin
            sel_d = cmd_q[3:0];
            en_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (be || tmo_hit) begin
          err_d = 1'b1;
          fst_d = F_HDR;
        end
      end
      default: fst_d = F_HDR;
    endcase
  end

  assign data_sel    = sel_q;
  assign data_sel_en = en_q;
  assign frame_err   = err_q;

endmodule

// File: tb/tb_uart_sel_rx.sv
// Directed bench for uart_sel_rx at 16 clocks per bit.
// Strobe cycles are checked against the byte start times.
module tb_uart_sel_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [3:0] data_sel;
  logic       data_sel_en;
  logic       frame_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int en_cnt = 0, err_cnt = 0, both_cnt = 0;
  int en_cyc = -1, err_cyc = -1;
  int last_start = 0;
  logic [3:0] sel_hist[$];

  localparam int LAT = 156;

  uart_sel_rx #(
    .CLK_FREQ    (1_600_000),
    .BAUD        (100_000),
    .TIMEOUT_CLKS(400)
  ) dut (
    .s_clk      (clk),
    .s_rst_n    (rst_n),
    .rx_in      (rx),
    .data_sel   (data_sel),
    .data_sel_en(data_sel_en),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (data_sel_en) begin
        en_cnt = en_cnt + 1;
        en_cyc = cyc;
        sel_hist.push_back(data_sel);
      end
      if (frame_err) begin
        err_cnt = err_cnt + 1;
        err_cyc = cyc;
      end
      if (data_sel_en && frame_err) both_cnt = both_cnt + 1;
    end
  end

  // called at a negedge; returns at a negedge
  task automatic send_byte(input logic [7:0] b, input logic stp);
    rx = 1'b0;
    last_start = cyc + 1;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) @(negedge clk);
    end
    rx = stp;
    repeat (16) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (data_sel !== 4'h0) begin
      bad++; $display("FAIL reset_sel got=%h want=0", data_sel);
    end
    total++;
    if (data_sel_en !== 1'b0) begin
      bad++; $display("FAIL reset_en got=%b want=0", data_sel_en);
    end
    total++;
    if (frame_err !== 1'b0) begin
      bad++; $display("FAIL reset_err got=%b want=0", frame_err);
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_valid();
    int e0, r0, st;
    e0 = en_cnt; r0 = err_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'hA6, 1'b1);
    st = last_start;
    repeat (8) @(negedge clk);
    total++;
    if (data_sel !== 4'h3) begin
      bad++; $display("FAIL valid_sel got=%h want=3", data_sel);
    end
    total++;
    if (en_cnt - e0 !== 1) begin
      bad++; $display("FAIL valid_en_cnt got=%0d want=1", en_cnt - e0);
    end
    total++;
    if (en_cyc !== st + LAT) begin
      bad++; $display("FAIL valid_latency got=%0d want=%0d", en_cyc, st + LAT);
    end
    total++;
    if (err_cnt - r0 !== 0) begin
      bad++; $display("FAIL valid_err got=%0d want=0", err_cnt - r0);
    end
  endtask

  task automatic test_bad_frames();
    int e0, r0, st;
    e0 = en_cnt; r0 = err_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h00, 1'b1);
    st = last_start;
    repeat (8) @(negedge clk);
    total++;
    if (err_cnt - r0 !== 1) begin
      bad++; $display("FAIL badsum_err got=%0d want=1", err_cnt - r0);
    end
    total++;
    if (err_cyc !== st + LAT) begin
      bad++; $display("FAIL badsum_latency got=%0d want=%0d", err_cyc, st + LAT);
    end
    total++;
    if (data_sel !== 4'h3) begin
      bad++; $display("FAIL badsum_sel got=%h want=3", data_sel);
    end
    r0 = err_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h13, 1'b1);
    st = last_start;
    send_byte(8'hB6, 1'b1);
    repeat (8) @(negedge clk);
    total++;
    if (err_cnt - r0 !== 1) begin
      bad++; $display("FAIL badcmd_err got=%0d want=1", err_cnt - r0);
    end
    total++;
    if (err_cyc !== st + LAT) begin
      bad++; $display("FAIL badcmd_latency got=%0d want=%0d", err_cyc, st + LAT);
    end
    total++;
    if (en_cnt - e0 !== 0) begin
      bad++; $display("FAIL bad_en got=%0d want=0", en_cnt - e0);
    end
  endtask

  task automatic test_glitch_resync();
    int e0, r0;
    e0 = en_cnt; r0 = err_cnt;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (60) @(negedge clk);
    total++;
    if (en_cnt - e0 + err_cnt - r0 !== 0) begin
      bad++; $display("FAIL glitch_strobes got=%0d want=0", en_cnt - e0 + err_cnt - r0);
    end
    send_byte(8'hA5, 1'b1);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h07, 1'b1);
    send_byte(8'hA2, 1'b1);
    repeat (8) @(negedge clk);
    total++;
    if (data_sel !== 4'h7) begin
      bad++; $display("FAIL resync_sel got=%h want=7", data_sel);
    end
    total++;
    if (en_cnt - e0 !== 1) begin
      bad++; $display("FAIL resync_en got=%0d want=1", en_cnt - e0);
    end
    total++;
    if (err_cnt - r0 !== 0) begin
      bad++; $display("FAIL resync_err got=%0d want=0", err_cnt - r0);
    end
  endtask

  task automatic test_timeout();
    int e0, r0, st;
    e0 = en_cnt; r0 = err_cnt;
    send_byte(8'hA5, 1'b1);
    st = last_start;
    repeat (500) @(negedge clk);
    total++;
    if (err_cnt - r0 !== 1) begin
      bad++; $display("FAIL tmo_err got=%0d want=1", err_cnt - r0);
    end
    total++;
    if (err_cyc !== st + LAT + 400) begin
      bad++; $display("FAIL tmo_cycle got=%0d want=%0d", err_cyc, st + LAT + 400);
    end
    send_byte(8'hA5, 1'b1);
    send_byte(8'h09, 1'b1);
    send_byte(8'hAC, 1'b1);
    repeat (8) @(negedge clk);
    total++;
    if (data_sel !== 4'h9) begin
      bad++; $display("FAIL tmo_after_sel got=%h want=9", data_sel);
    end
    total++;
    if (en_cnt - e0 !== 1) begin
      bad++; $display("FAIL tmo_en got=%0d want=1", en_cnt - e0);
    end
  endtask

  task automatic test_stop_err_reset();
    int e0, r0, st;
    e0 = en_cnt; r0 = err_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h04, 1'b0);
    st = last_start;
    repeat (20) @(negedge clk);
    total++;
    if (err_cnt - r0 !== 1) begin
      bad++; $display("FAIL stoperr_err got=%0d want=1", err_cnt - r0);
    end
    total++;
    if (err_cyc !== st + LAT) begin
      bad++; $display("FAIL stoperr_latency got=%0d want=%0d", err_cyc, st + LAT);
    end
    total++;
    if (en_cnt - e0 !== 0) begin
      bad++; $display("FAIL stoperr_en got=%0d want=0", en_cnt - e0);
    end
    send_byte(8'hA5, 1'b1);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (data_sel !== 4'h0) begin
      bad++; $display("FAIL midrst_sel got=%h want=0", data_sel);
    end
    total++;
    if ({data_sel_en, frame_err} !== 2'b00) begin
      bad++; $display("FAIL midrst_strobes got=%b want=00", {data_sel_en, frame_err});
    end
    rx = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    e0 = en_cnt; r0 = err_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'hA7, 1'b1);
    repeat (8) @(negedge clk);
    total++;
    if (data_sel !== 4'h2) begin
      bad++; $display("FAIL postrst_sel got=%h want=2", data_sel);
    end
    total++;
    if (en_cnt - e0 !== 1 || err_cnt - r0 !== 0) begin
      bad++; $display("FAIL postrst_strobes got en=%0d err=%0d want en=1 err=0", en_cnt - e0, err_cnt - r0);
    end
  endtask

  task automatic test_back_to_back();
    int e0, r0;
    e0 = en_cnt; r0 = err_cnt;
    sel_hist.delete();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'hA4, 1'b1);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h0F, 1'b1);
    send_byte(8'hAA, 1'b1);
    repeat (8) @(negedge clk);
    total++;
    if (en_cnt - e0 !== 2) begin
      bad++; $display("FAIL b2b_en got=%0d want=2", en_cnt - e0);
    end
    total++;
    if (sel_hist.size() != 2 || sel_hist[0] !== 4'h1 || sel_hist[1] !== 4'hF) begin
      bad++; $display("FAIL b2b_sel_seq got n=%0d want 1,F", sel_hist.size());
    end
    total++;
    if (data_sel !== 4'hF) begin
      bad++; $display("FAIL b2b_sel got=%h want=F", data_sel);
    end
    total++;
    if (err_cnt - r0 !== 0) begin
      bad++; $display("FAIL b2b_err got=%0d want=0", err_cnt - r0);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_valid();
    test_bad_frames();
    test_glitch_resync();
    test_timeout();
    test_stop_err_reset();
    test_back_to_back();
    total++;
    if (both_cnt !== 0) begin
      bad++; $display("FAIL strobe_overlap got=%0d want=0", both_cnt);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
